// File: rtl/seq_pkg.sv
// seq_pkg: shared state type, default pattern and counter sizing for seq_gen
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} seq_state_t;
  localparam logic [7:0] SEQ_PATTERN = 8'hED;
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_gen_tick.sv
// seq_gen_tick: bit-period prescaler, pulses on the last cycle of each bit
module seq_gen_tick import seq_pkg::*; #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = cnt_w(BIT_CYCLES);
  logic [CW-1:0] cyc_cnt;
  assign tick_o = en_i && cyc_cnt == CW'(BIT_CYCLES - 1);
  always_ff @(posedge clk_i)
    cyc_cnt <= (rst_i || !en_i || tick_o) ? '0 : cyc_cnt + 1'b1;
endmodule

// File: rtl/seq_gen.sv
// seq_gen: MSB-first serial frame transmitter with start qualifier and idle gap
module seq_gen import seq_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              start_o,
  output logic              serial_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int BW = cnt_w(DATA_W);
  localparam int GW = cnt_w(GAP_CYCLES);
  seq_state_t        state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              tick, last, gap_end;
  seq_gen_tick #(.BIT_CYCLES(BIT_CYCLES)) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state == SHIFT),
    .tick_o(tick)
  );
  assign last     = tick && bit_cnt == BW'(DATA_W - 1);
  assign gap_end  = gap_cnt == GW'(GAP_CYCLES - 1);
  assign ready_o  = state == IDLE && !rst_i;
  assign start_o  = state == SHIFT;
  assign serial_o = start_o && shreg[DATA_W-1];
  assign busy_o   = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      done_o  <= 1'b0;
    end else begin
      done_o <= state == SHIFT && last;
      case (state)
        IDLE: if (valid_i) begin
          shreg   <= data_i;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: if (tick) begin
          shreg   <= shreg << 1;
          bit_cnt <= last ? '0 : bit_cnt + 1'b1;
          if (last) state <= GAP_CYCLES == 0 ? IDLE : GAP;
        end
        GAP: begin
          gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
          if (gap_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized self-checking bench for seq_gen across three parameter sets
module tb_seq_gen;
  import seq_pkg::*;
  localparam int DW [3] = '{8, 4, 8};
  localparam int BC [3] = '{1, 3, 1};
  localparam int GC [3] = '{2, 2, 0};
  logic clk = 0, rst = 1;
  logic [2:0] valid = '0, rdy, st, ser, bsy, dn;
  logic [7:0] data [3];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  seq_gen #(.DATA_W(8), .BIT_CYCLES(1), .GAP_CYCLES(2)) d0 (
    .clk_i(clk), .rst_i(rst), .data_i(data[0]), .valid_i(valid[0]), .ready_o(rdy[0]),
    .start_o(st[0]), .serial_o(ser[0]), .busy_o(bsy[0]), .done_o(dn[0]));
  seq_gen #(.DATA_W(4), .BIT_CYCLES(3), .GAP_CYCLES(2)) d1 (
    .clk_i(clk), .rst_i(rst), .data_i(data[1][3:0]), .valid_i(valid[1]), .ready_o(rdy[1]),
    .start_o(st[1]), .serial_o(ser[1]), .busy_o(bsy[1]), .done_o(dn[1]));
  seq_gen #(.DATA_W(8), .BIT_CYCLES(1), .GAP_CYCLES(0)) d2 (
    .clk_i(clk), .rst_i(rst), .data_i(data[2]), .valid_i(valid[2]), .ready_o(rdy[2]),
    .start_o(st[2]), .serial_o(ser[2]), .busy_o(bsy[2]), .done_o(dn[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected {ready,start,serial,busy,done} in cycle E+t of a frame handshaken at edge E
  function automatic logic [4:0] model(int i, logic [7:0] w, int t);
    int len = DW[i] * BC[i];
    logic on = t <= len;
    logic bit_v = on ? w[DW[i] - 1 - (t - 1) / BC[i]] : 1'b0;
    logic rd = t >= len + GC[i] + 1;
    return {rd, on, bit_v, !rd, t == len + 1};
  endfunction

  // junk: 0 quiet, 1 random valid/data while busy, 2 valid with all-ones while busy
  task automatic test_frame(int i, logic [7:0] w, int junk, logic hold, logic [7:0] nxt);
    int n = DW[i] * BC[i] + GC[i] + 1;
    logic [4:0] obs;
    checks++;
    if (rdy[i] !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_frame inst%0d got %b exp 1", i, rdy[i]);
    end
    valid[i] = 1'b1;
    data[i] = w;
    step();
    valid[i] = hold;
    data[i] = nxt;
    for (int t = 1; t <= n; t++) begin
      obs = {rdy[i], st[i], ser[i], bsy[i], dn[i]};
      checks++;
      if (obs !== model(i, w, t)) begin
        errors++;
        $display("FAIL frame inst%0d word %h t=%0d got rdy/st/ser/bsy/dn=%b exp %b", i, w, t, obs, model(i, w, t));
      end
      if (t == n) break;
      if (!hold && junk == 1) begin
        valid[i] = 1'($urandom);
        data[i] = 8'($urandom);
      end
      if (!hold && junk == 2) begin
        valid[i] = 1'b1;
        data[i] = 8'hFF;
      end
      step();
    end
    valid[i] = hold;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) step();
    rst = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rdy[i], st[i], ser[i], bsy[i], dn[i]} !== 5'b10000) begin
        errors++;
        $display("FAIL reset inst%0d got %b exp 10000", i, {rdy[i], st[i], ser[i], bsy[i], dn[i]});
      end
    end
  endtask

  task automatic test_basic();
    test_frame(0, SEQ_PATTERN, 0, 1'b0, 8'h00);
    step();
    test_frame(1, 8'h0A, 0, 1'b0, 8'h00);
    step();
  endtask

  task automatic test_back_to_back();
    test_frame(2, 8'hA5, 0, 1'b1, 8'h3C);
    test_frame(2, 8'h3C, 0, 1'b0, 8'h00);
    step();
  endtask

  task automatic test_busy_lockout();
    test_frame(0, 8'h00, 2, 1'b0, 8'h00);
    step();
    checks++;
    if (bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL lockout_requeue got busy %b exp 0", bsy[0]);
    end
  endtask

  task automatic test_mid_reset();
    valid[0] = 1'b1;
    data[0] = 8'hED;
    step();
    valid[0] = 1'b0;
    repeat (3) step();
    rst = 1;
    step();
    checks++;
    if ({rdy[0], st[0], ser[0], bsy[0], dn[0]} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_reset got %b exp 00000", {rdy[0], st[0], ser[0], bsy[0], dn[0]});
    end
    rst = 0;
    step();
    checks++;
    if ({rdy[0], st[0], ser[0], bsy[0], dn[0]} !== 5'b10000) begin
      errors++;
      $display("FAIL after_reset got %b exp 10000", {rdy[0], st[0], ser[0], bsy[0], dn[0]});
    end
  endtask

  task automatic test_reset_vs_handshake();
    rst = 1;
    valid[0] = 1'b1;
    data[0] = 8'hFF;
    step();
    rst = 0;
    valid[0] = 1'b0;
    step();
    checks++;
    if ({rdy[0], st[0], bsy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL reset_wins got rdy/st/bsy=%b exp 100", {rdy[0], st[0], bsy[0]});
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      int i = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) step();
      test_frame(i, 8'($urandom), 1, 1'b0, 8'h00);
      step();
    end
  endtask

  initial begin
    data = '{8'h00, 8'h00, 8'h00};
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_lockout();
    test_mid_reset();
    test_reset_vs_handshake();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
